// File: rtl/spi_reg_controller_if.sv
// Request and SPI pin bundle for spi_reg_controller.
// master: the controller side; slave: the requester and pin observer.
interface spi_reg_controller_if;
  logic       start;
  logic       rw;
  logic [6:0] addr;
  logic [7:0] wdata;
  logic       busy;
  logic       done;
  logic       nCS;
  logic       SCLK;
  logic       COPI;

  modport master (
    input  start, rw, addr, wdata,
    output busy, done, nCS, SCLK, COPI
  );

  modport slave (
    output start, rw, addr, wdata,
    input  busy, done, nCS, SCLK, COPI
  );
endinterface

// File: rtl/spi_reg_controller.sv
// Write-only SPI mode-0 initiator: one 16-bit {rw, addr, data} frame per
// accepted request, followed by a chip-select-high gap.
module spi_reg_controller #(
  parameter int CLK_DIV = 4,
  parameter int GAP_HP  = 2
) (
  input logic clk,
  input logic rst,
  spi_reg_controller_if.master bus
);

  localparam int GW = (GAP_HP > 1) ? $clog2(GAP_HP) : 1;
  localparam logic [7:0]    LAST  = 8'(CLK_DIV - 1);
  localparam logic [GW-1:0] GLAST = GW'(GAP_HP - 1);

  typedef enum logic [2:0] {
    IDLE, SETUP, SHIFT, HOLD, GAP
  } state_t;

  state_t        state;
  logic [14:0]   sh;
  logic [4:0]    bit_cnt;
  logic [7:0]    cnt;
  logic [GW-1:0] gap_cnt;

  // Frame sequencer; the bit currently on COPI is held in the output
  // register, sh keeps the bits still to be sent.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      sh       <= '0;
      bit_cnt  <= '0;
      cnt      <= '0;
      gap_cnt  <= '0;
      bus.nCS  <= 1'b1;
      bus.SCLK <= 1'b0;
      bus.COPI <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            sh       <= {bus.addr, bus.wdata};
            bit_cnt  <= '0;
            cnt      <= '0;
            bus.COPI <= bus.rw;
            bus.nCS  <= 1'b0;
            bus.busy <= 1'b1;
            state    <= SETUP;
          end
        end
        SETUP: begin
          if (cnt == LAST) begin
            cnt      <= '0;
            bus.SCLK <= 1'b1;
            state    <= SHIFT;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        SHIFT: begin
          if (cnt != LAST) begin
            cnt <= cnt + 8'd1;
          end else begin
            cnt <= '0;
            if (bus.SCLK) begin
              bus.SCLK <= 1'b0;
              if (bit_cnt != 5'd15) begin
                sh       <= {sh[13:0], 1'b0};
                bus.COPI <= sh[14];
              end
            end else if (bit_cnt == 5'd15) begin
              state <= HOLD;
            end else begin
              bus.SCLK <= 1'b1;
              bit_cnt  <= bit_cnt + 5'd1;
            end
          end
        end
        HOLD: begin
          if (cnt != LAST) begin
            cnt <= cnt + 8'd1;
          end else begin
            cnt      <= '0;
            gap_cnt  <= '0;
            bus.nCS  <= 1'b1;
            bus.COPI <= 1'b0;
            state    <= GAP;
          end
        end
        GAP: begin
          if (cnt != LAST) begin
            cnt <= cnt + 8'd1;
          end else begin
            cnt <= '0;
            if (gap_cnt == GLAST) begin
              bus.busy <= 1'b0;
              bus.done <= 1'b1;
              state    <= IDLE;
            end else begin
              gap_cnt <= gap_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_reg_controller.sv
// Self-checking bench for spi_reg_controller: random frames compared
// against frame timing and bit order computed from the SPI frame rules.
module tb_spi_reg_controller;

  localparam int C  = 4;
  localparam int G  = 2;
  localparam int C2 = 2;
  localparam int G2 = 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spi_reg_controller_if b0();
  spi_reg_controller_if b1();

  spi_reg_controller #(.CLK_DIV(C), .GAP_HP(G)) dut (
    .clk(clk), .rst(rst), .bus(b0)
  );

  spi_reg_controller #(.CLK_DIV(C2), .GAP_HP(G2)) dut2 (
    .clk(clk), .rst(rst), .bus(b1)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  int   rise_cyc[$];
  logic rise_bit[$];
  int   done_cyc[$];
  int   fall_cyc[$];
  int   up_cyc[$];
  logic p_sclk = 1'b0;
  logic p_ncs  = 1'b1;

  // Event log of the main instance pins, sampled mid-cycle.
  always @(negedge clk) begin
    if (!p_sclk && b0.SCLK === 1'b1) begin
      rise_cyc.push_back(cyc);
      rise_bit.push_back(b0.COPI);
    end
    if (p_ncs && b0.nCS === 1'b0) fall_cyc.push_back(cyc);
    if (!p_ncs && b0.nCS === 1'b1) up_cyc.push_back(cyc);
    if (b0.done === 1'b1) done_cyc.push_back(cyc);
    p_sclk <= b0.SCLK;
    p_ncs  <= b0.nCS;
  end

  task automatic clear_log();
    rise_cyc.delete();
    rise_bit.delete();
    done_cyc.delete();
    fall_cyc.delete();
    up_cyc.delete();
  endtask

  task automatic drive0(input logic [15:0] f);
    b0.rw    = f[15];
    b0.addr  = f[14:8];
    b0.wdata = f[7:0];
  endtask

  task automatic wait_done0(input int limit);
    for (int n = 0; n < limit && done_cyc.size() == 0; n++)
      @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    b0.start = 0; b0.rw = 0; b0.addr = 0; b0.wdata = 0;
    b1.start = 0; b1.rw = 0; b1.addr = 0; b1.wdata = 0;
    repeat (3) @(negedge clk);
    total++; if (b0.nCS !== 1'b1) begin bad++; $display("FAIL reset_ncs got=%b want=1", b0.nCS); end
    total++; if (b0.SCLK !== 1'b0) begin bad++; $display("FAIL reset_sclk got=%b want=0", b0.SCLK); end
    total++; if (b0.COPI !== 1'b0) begin bad++; $display("FAIL reset_copi got=%b want=0", b0.COPI); end
    total++; if (b0.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", b0.busy); end
    total++; if (b0.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", b0.done); end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (b0.busy !== 1'b0 || b0.nCS !== 1'b1) begin
      bad++; $display("FAIL idle_after_reset busy=%b ncs=%b want 0/1", b0.busy, b0.nCS);
    end
  endtask

  task automatic test_frame();
    logic [15:0] f, w;
    int c, F, terr, got;
    for (int i = 0; i < 5; i++) begin
      f = (i == 0) ? 16'h80F0 : 16'($urandom);
      clear_log();
      drive0(f);
      b0.start = 1'b1;
      c = cyc;
      @(negedge clk);
      b0.start = 1'b0;
      drive0(16'($urandom));
      wait_done0(400);
      repeat (3) @(negedge clk);
      F = c + 1;
      got = fall_cyc.size() > 0 ? fall_cyc[0] : -1;
      total++; if (got !== F) begin bad++; $display("FAIL frame%0d_ncs_fall got=%0d want=%0d", i, got, F); end
      total++; if (rise_cyc.size() !== 16) begin
        bad++; $display("FAIL frame%0d_rises got=%0d want=16", i, rise_cyc.size());
      end
      w = '0;
      foreach (rise_bit[k]) if (k < 16) w[15-k] = rise_bit[k];
      total++; if (w !== f) begin bad++; $display("FAIL frame%0d_bits got=%h want=%h", i, w, f); end
      terr = 0;
      foreach (rise_cyc[k]) if (rise_cyc[k] != F + C * (1 + 2 * k)) terr++;
      total++; if (terr !== 0) begin bad++; $display("FAIL frame%0d_rise_time got=%0d_off want=0", i, terr); end
      got = up_cyc.size() > 0 ? up_cyc[0] : -1;
      total++; if (got !== F + 34 * C) begin
        bad++; $display("FAIL frame%0d_ncs_rise got=%0d want=%0d", i, got, F + 34 * C);
      end
      got = done_cyc.size() > 0 ? done_cyc[0] : -1;
      total++; if (done_cyc.size() !== 1 || got !== c + 145) begin
        bad++; $display("FAIL frame%0d_done n=%0d at=%0d want 1 at %0d", i, done_cyc.size(), got, c + 145);
      end
    end
  endtask

  task automatic test_busy_ignore();
    logic [15:0] f, w;
    int c;
    f = 16'($urandom) | 16'h8000;
    clear_log();
    drive0(f);
    b0.start = 1'b1;
    c = cyc;
    @(negedge clk);
    b0.start = 1'b0;
    repeat (19) @(negedge clk);
    drive0(~f);
    b0.start = 1'b1;
    @(negedge clk);
    b0.start = 1'b0;
    wait_done0(400);
    repeat (30) @(negedge clk);
    w = '0;
    foreach (rise_bit[k]) if (k < 16) w[15-k] = rise_bit[k];
    total++; if (w !== f) begin bad++; $display("FAIL busy_latch got=%h want=%h", w, f); end
    total++; if (rise_cyc.size() !== 16) begin
      bad++; $display("FAIL busy_rises got=%0d want=16", rise_cyc.size());
    end
    total++; if (fall_cyc.size() !== 1 || done_cyc.size() !== 1) begin
      bad++; $display("FAIL busy_queued frames=%0d dones=%0d want 1/1", fall_cyc.size(), done_cyc.size());
    end
    total++; if (b0.busy !== 1'b0) begin bad++; $display("FAIL busy_after got=%b want=0", b0.busy); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] fr [3];
    logic [15:0] w;
    int k, herr, derr;
    for (int i = 0; i < 3; i++) fr[i] = 16'($urandom);
    clear_log();
    drive0(fr[0]);
    b0.start = 1'b1;
    k = 0;
    for (int n = 0; n < 1000 && k < 3; n++) begin
      @(negedge clk);
      if (b0.done === 1'b1) begin
        k++;
        if (k < 3) drive0(fr[k]);
        else b0.start = 1'b0;
      end
    end
    b0.start = 1'b0;
    repeat (20) @(negedge clk);
    total++; if (done_cyc.size() !== 3) begin bad++; $display("FAIL b2b_dones got=%0d want=3", done_cyc.size()); end
    total++; if (rise_cyc.size() !== 48) begin bad++; $display("FAIL b2b_rises got=%0d want=48", rise_cyc.size()); end
    for (int j = 0; j < 3; j++) begin
      w = '0;
      for (int b = 0; b < 16; b++)
        if (16 * j + b < rise_bit.size()) w[15-b] = rise_bit[16*j+b];
      total++; if (w !== fr[j]) begin bad++; $display("FAIL b2b_bits%0d got=%h want=%h", j, w, fr[j]); end
    end
    herr = 0;
    derr = 0;
    if (fall_cyc.size() == 3 && up_cyc.size() >= 2 && done_cyc.size() == 3) begin
      for (int j = 0; j < 2; j++) if (fall_cyc[j+1] - up_cyc[j] != G * C + 1) herr++;
      for (int j = 0; j < 3; j++) if (done_cyc[j] != fall_cyc[j] + C * (34 + G)) derr++;
    end else begin
      herr = 99;
    end
    total++; if (herr !== 0) begin bad++; $display("FAIL b2b_gap got=%0d_off want=0", herr); end
    total++; if (derr !== 0) begin bad++; $display("FAIL b2b_done_time got=%0d_off want=0", derr); end
  endtask

  task automatic test_reset_mid();
    clear_log();
    drive0(16'($urandom) | 16'h8000);
    b0.start = 1'b1;
    @(negedge clk);
    b0.start = 1'b0;
    for (int n = 0; n < 400 && rise_cyc.size() < 7; n++) @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++; if (b0.nCS !== 1'b1 || b0.SCLK !== 1'b0) begin
      bad++; $display("FAIL rstmid_pins ncs=%b sclk=%b want 1/0", b0.nCS, b0.SCLK);
    end
    total++; if (b0.busy !== 1'b0 || b0.COPI !== 1'b0) begin
      bad++; $display("FAIL rstmid_busy busy=%b copi=%b want 0/0", b0.busy, b0.COPI);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (200) @(negedge clk);
    total++; if (done_cyc.size() !== 0) begin bad++; $display("FAIL rstmid_done got=%0d want=0", done_cyc.size()); end
    total++; if (rise_cyc.size() !== 7) begin bad++; $display("FAIL rstmid_rises got=%0d want=7", rise_cyc.size()); end
  endtask

  task automatic test_div2();
    logic [15:0] f, w;
    logic ps;
    int nr, fall_n, done_n, nd, first_r, last_r;
    for (int i = 0; i < 3; i++) begin
      f = (i == 0) ? {1'b0, 7'h01, 8'($urandom)} : {1'b0, 15'($urandom)};
      b1.rw = f[15]; b1.addr = f[14:8]; b1.wdata = f[7:0];
      b1.start = 1'b1;
      ps = b1.SCLK;
      nr = 0; fall_n = -1; done_n = -1; nd = 0; first_r = -1; last_r = -1;
      w = '0;
      for (int n = 1; n <= 120; n++) begin
        @(negedge clk);
        if (n == 1) b1.start = 1'b0;
        if (!ps && b1.SCLK === 1'b1) begin
          if (nr < 16) w[15-nr] = b1.COPI;
          if (nr == 0) first_r = n;
          last_r = n;
          nr++;
        end
        if (fall_n < 0 && b1.nCS === 1'b0) fall_n = n;
        if (b1.done === 1'b1) begin nd++; done_n = n; end
        ps = b1.SCLK;
      end
      total++; if (w !== f) begin bad++; $display("FAIL div2_bits%0d got=%h want=%h", i, w, f); end
      total++; if (nr !== 16) begin bad++; $display("FAIL div2_rises%0d got=%0d want=16", i, nr); end
      total++; if (fall_n !== 1 || first_r !== 1 + C2 || last_r !== 1 + C2 * 31) begin
        bad++; $display("FAIL div2_timing%0d fall=%0d first=%0d last=%0d want 1/%0d/%0d",
                        i, fall_n, first_r, last_r, 1 + C2, 1 + C2 * 31);
      end
      total++; if (nd !== 1 || done_n !== 1 + C2 * (34 + G2)) begin
        bad++; $display("FAIL div2_done%0d n=%0d at=%0d want 1 at %0d", i, nd, done_n, 1 + C2 * (34 + G2));
      end
    end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    test_div2();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

endmodule
